// File: rtl/monitor_rco.sv
// Rollover monitor: counts rising edges of an upstream ripple-carry, reports {rollovers, count_in} once it reaches a threshold.
// Optional sticky wrap flag on ovf is enabled by defining MONITOR_RCO_OVF_EN.
module monitor_rco #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   count_in,
    input  logic         rco_in,
    input  logic         start,
    input  logic [N+3:0] thresh,
    input  logic         ack,
    output logic [N-1:0] rollovers,
    output logic [N+3:0] snap,
    output logic         valid,
    output logic         busy,
    output logic         ovf
);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t       state, state_next;
    logic         rco_q;
    logic [N+3:0] thresh_q;
    logic         rise, accept, hit, count_en;

    always_comb begin
        state_next = state;
        rise       = rco_in & ~rco_q;
        accept     = 1'b0;
        hit        = 1'b0;
        count_en   = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_next = RUN;
            end
            RUN: begin
                count_en = rise;
                // Compare uses current register values; a wrap simply lowers the value.
                hit = ({rollovers, count_in} >= thresh_q);
                if (hit) state_next = REPORT;
            end
            REPORT: begin
                count_en = rise;
                if (ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rco_q     <= 1'b0;
            rollovers <= '0;
            thresh_q  <= '0;
            snap      <= '0;
            valid     <= 1'b0;
        end else begin
            rco_q <= rco_in;
            if (accept) begin
                rollovers <= '0;
                thresh_q  <= thresh;
            end else if (count_en) begin
                rollovers <= rollovers + N'(1);
            end
            // snap takes the pre-increment value when an edge lands on the hit cycle
            if (hit) begin
                snap  <= {rollovers, count_in};
                valid <= 1'b1;
            end else if (state == REPORT && ack) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef MONITOR_RCO_OVF_EN
    always_ff @(posedge clk) begin
        if (reset || accept)
            ovf <= 1'b0;
        else if (count_en && (&rollovers))
            ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/monitor_rco.md
MONITOR_RCO -- requirements
Module: monitor_rco

Interface
REQ-001 Parameter N, default 8, width of the rollover counter (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 count_in  input  4  low nibble from the upstream 4-bit counter.
REQ-005 rco_in  input  1  ripple-carry level from the upstream counter; may stay high for several cycles.
REQ-006 start  input  1  arms a measurement when idle.
REQ-007 thresh  input  N+4  hit threshold, sampled only when start is accepted.
REQ-008 ack  input  1  consumer acknowledge for the report.
REQ-009 rollovers  output  N  count of rco_in rising edges since the last accepted start.
REQ-010 snap  output  N+4  captured {rollovers, count_in} at hit.
REQ-011 valid  output  1  snap is valid and awaiting ack.
REQ-012 busy  output  1  high in RUN or REPORT.
REQ-013 ovf  output  1  sticky rollover-counter wrap flag (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, REPORT; busy = (state != IDLE), registered.
REQ-015 The rco_in edge SHALL be detected as rco_in=1 while the registered previous sample rco_q=0; rco_q SHALL update every cycle in all states.
REQ-016 IDLE with start=1 SHALL go to RUN next cycle, clear rollovers to 0, clear ovf, and latch thresh into thresh_q.
REQ-017 start SHALL be ignored in RUN and REPORT; thresh changes after acceptance SHALL have no effect.
REQ-018 In RUN and REPORT, each detected edge SHALL increment rollovers by 1 on the next cycle, modulo 2^N (all-ones wraps to 0).
REQ-019 In IDLE, rollovers SHALL hold its value and edges SHALL NOT be counted.
REQ-020 In RUN, when {rollovers, count_in} >= thresh_q (unsigned, current register values), the FSM SHALL go to REPORT, load snap with that value, and set valid, all on the same edge.
REQ-021 thresh_q = 0 SHALL produce a hit in the first RUN cycle.
REQ-022 An edge and a hit in the same cycle SHALL both take effect; snap SHALL hold the pre-increment value.
REQ-023 In REPORT, snap and valid SHALL hold stable while ack=0; rollovers SHALL keep counting.
REQ-024 In REPORT with ack=1, valid SHALL clear and the FSM SHALL go to IDLE next cycle; snap SHALL retain its value.
REQ-025 ack outside REPORT SHALL be ignored.
REQ-026 The compare SHALL evaluate only in RUN; a wrap-induced lower value SHALL NOT produce a hit by itself.

Reset
REQ-027 reset=1 at a rising edge SHALL force state=IDLE, rollovers=0, snap=0, valid=0, busy=0, ovf=0, thresh_q=0, rco_q=0, overriding all other inputs.
REQ-028 reset asserted mid-RUN or mid-REPORT SHALL abort the measurement with no report; a pending valid SHALL be dropped.

Configuration
REQ-029 Macro MONITOR_RCO_OVF_EN: when defined, ovf SHALL set on the cycle rollovers wraps from all-ones to 0 and stay set until reset or an accepted start.
REQ-030 When MONITOR_RCO_OVF_EN is undefined, ovf SHALL be constant 0 and no wrap-detection logic SHALL be present; all other behaviour SHALL be unchanged.

Verification
REQ-031 N=8, start with thresh=0x025, 2 rco_in edges, then count_in reaches 5 -> valid=1 with snap=0x025 one cycle after the compare; ack -> valid=0 and busy=0 next cycle.
REQ-032 rco_in held high 16 cycles -> rollovers increments exactly once.
REQ-033 start with thresh=0 -> valid=1 on the second cycle after start, with snap={0, count_in}.
REQ-034 In REPORT, hold ack=0 for 10 cycles while changing count_in and applying an edge -> snap unchanged, rollovers +1.
REQ-035 OVF_EN defined, thresh=0xFFF, 256 edges -> rollovers=0, ovf=1 and held; new start -> ovf=0. Without OVF_EN -> ovf stays 0.
REQ-036 reset pulse while valid=1 -> next cycle state IDLE and all outputs 0; a start in the same cycle as reset is ignored.
